// File: rtl/store_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer_if
// Purpose  : Bundles the writeback-side enqueue port, the dcache drain
//            handshake, the load-conflict probe and the occupancy status
//            of the store write buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface store_write_buffer_if #(
  parameter int PTR_W = 2
);
  // Writeback enqueue side
  logic             WB_wr_valid;
  logic [31:0]      WB_wr_address;
  logic [63:0]      WB_wr_data;
  logic [1:0]       WB_wr_size;
  logic             In_write_ready;

  // Dcache drain side
  logic             DC_wr_req;
  logic [31:0]      DC_wr_address;
  logic [63:0]      DC_wr_data;
  logic [1:0]       DC_wr_size;
  logic             DC_wr_ack;

  // Memory-stage load probe
  logic [31:0]      LD_probe_address;
  logic             LD_probe_conflict;

  // Occupancy status
  logic [PTR_W:0]   WBUF_count;
  logic             WBUF_empty;

  // The buffer itself
  modport slave (
    input  WB_wr_valid, WB_wr_address, WB_wr_data, WB_wr_size,
    input  DC_wr_ack, LD_probe_address,
    output In_write_ready,
    output DC_wr_req, DC_wr_address, DC_wr_data, DC_wr_size,
    output LD_probe_conflict, WBUF_count, WBUF_empty
  );

  // The surrounding pipeline / dcache
  modport master (
    output WB_wr_valid, WB_wr_address, WB_wr_data, WB_wr_size,
    output DC_wr_ack, LD_probe_address,
    input  In_write_ready,
    input  DC_wr_req, DC_wr_address, DC_wr_data, DC_wr_size,
    input  LD_probe_conflict, WBUF_count, WBUF_empty
  );
endinterface
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer
// Purpose  : In-order FIFO of dcache stores between writeback and the dcache.
//            Drains one store per ack, exposes ready for writeback stalls and
//            an 8-byte-block conflict probe for memory-stage loads.
// Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic             CLK,
  input  wire logic             CLR,
  store_write_buffer_if.slave   bus
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [31:0]      entry_addr [DEPTH];
  logic [63:0]      entry_data [DEPTH];
  logic [1:0]       entry_size [DEPTH];
  logic [DEPTH-1:0] entry_valid;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic             ready;
  logic             enq;
  logic             deq;
  logic [DEPTH-1:0] probe_hit;

  // Ready depends only on registered occupancy, so an ack arriving while
  // full cannot open the door in the same cycle.
  assign ready = (count != FULL_COUNT);
  assign enq   = bus.WB_wr_valid & ready;
  assign deq   = bus.DC_wr_ack & entry_valid[rd_ptr];

  // Head/tail pointers advance on enqueue and dequeue respectively.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy counter; simultaneous enqueue and dequeue cancel out.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      count <= '0;
    end else begin
      case ({enq, deq})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Per-entry valid bits. Enqueue and dequeue never target the same slot
  // in one cycle: that would need the buffer both empty and non-empty.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      entry_valid <= '0;
    end else begin
      if (enq) entry_valid[wr_ptr] <= 1'b1;
      if (deq) entry_valid[rd_ptr] <= 1'b0;
    end
  end

  // Store payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (enq) begin
      entry_addr[wr_ptr] <= bus.WB_wr_address;
      entry_data[wr_ptr] <= bus.WB_wr_data;
      entry_size[wr_ptr] <= bus.WB_wr_size;
    end
  end

  // Block-granular (8-byte) address match against every buffered store.
  for (genvar i = 0; i < DEPTH; i++) begin : g_probe
    assign probe_hit[i] = entry_valid[i] &
                          (entry_addr[i][31:3] == bus.LD_probe_address[31:3]);
  end

  assign bus.In_write_ready    = ready;
  assign bus.DC_wr_req         = entry_valid[rd_ptr];
  assign bus.DC_wr_address     = entry_addr[rd_ptr];
  assign bus.DC_wr_data        = entry_data[rd_ptr];
  assign bus.DC_wr_size        = entry_size[rd_ptr];
  assign bus.LD_probe_conflict = |probe_hit;
  assign bus.WBUF_count        = count;
  assign bus.WBUF_empty        = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_write_buffer
// Purpose  : Self-checking bench for store_write_buffer. A queue-based model
//            tracks buffer contents; a scoreboard queue holds stores in the
//            order dcache must receive them and a monitor pops on each ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic CLK = 1'b0;
  logic CLR = 1'b0;

  always #5 CLK = ~CLK;

  store_write_buffer_if #(.PTR_W(PTR_W)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } entry_t;

  entry_t model_q[$];   // current buffer contents, head first
  entry_t exp_q[$];     // scoreboard: stores dcache must see, in order
  entry_t mon_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_conflict(input logic [31:0] p);
    foreach (model_q[i])
      if (model_q[i].addr[31:3] == p[31:3]) return 1'b1;
    return 1'b0;
  endfunction

  // Compare visible state against the model between edges.
  task automatic check_state();
    chk("count", 64'(bus.WBUF_count), 64'(model_q.size()));
    chk("empty", 64'(bus.WBUF_empty), 64'(model_q.size() == 0));
    chk("ready", 64'(bus.In_write_ready), 64'(model_q.size() < DEPTH));
    chk("req",   64'(bus.DC_wr_req), 64'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      chk("head_addr", 64'(bus.DC_wr_address), 64'(model_q[0].addr));
      chk("head_data", bus.DC_wr_data, model_q[0].data);
      chk("head_size", 64'(bus.DC_wr_size), 64'(model_q[0].size));
    end
    chk("conflict", 64'(bus.LD_probe_conflict), 64'(model_conflict(bus.LD_probe_address)));
  endtask

  // One clock of stimulus: drive at negedge, check, then update the model
  // with whatever the edge accepted.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [63:0] d,
                       input logic [1:0] s, input logic ack, input logic [31:0] probe,
                       output logic accepted);
    logic   enq;
    logic   deq;
    entry_t e;
    @(negedge CLK);
    bus.WB_wr_valid      = v;
    bus.WB_wr_address    = a;
    bus.WB_wr_data       = d;
    bus.WB_wr_size       = s;
    bus.DC_wr_ack        = ack;
    bus.LD_probe_address = probe;
    #1;
    check_state();
    enq    = v && (model_q.size() < DEPTH);
    deq    = ack && (model_q.size() > 0);
    e.addr = a;
    e.data = d;
    e.size = s;
    if (enq) exp_q.push_back(e);
    accepted = enq;
    @(posedge CLK);
    if (deq) void'(model_q.pop_front());
    if (enq) model_q.push_back(e);
  endtask

  // Monitor: every ack on a presented request retires the oldest store.
  always @(negedge CLK) begin
    #2;
    if (CLR && bus.DC_wr_req && bus.DC_wr_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_order: got store addr %h, required none", bus.DC_wr_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", 64'(bus.DC_wr_address), 64'(mon_e.addr));
        chk("drain_data", bus.DC_wr_data, mon_e.data);
        chk("drain_size", 64'(bus.DC_wr_size), 64'(mon_e.size));
      end
    end
  end

  function automatic logic [63:0] rand_data(input logic [1:0] s);
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    if (s != 2'b11) d[63:32] = '0;
    return d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},      64'(bus.DC_wr_req), 64'd0);
    chk({tag, "_empty"},    64'(bus.WBUF_empty), 64'd1);
    chk({tag, "_ready"},    64'(bus.In_write_ready), 64'd1);
    chk({tag, "_count"},    64'(bus.WBUF_count), 64'd0);
    chk({tag, "_conflict"}, 64'(bus.LD_probe_conflict), 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] p;
    int          tries;

    bus.WB_wr_valid      = 1'b0;
    bus.WB_wr_address    = '0;
    bus.WB_wr_data       = '0;
    bus.WB_wr_size       = '0;
    bus.DC_wr_ack        = 1'b0;
    bus.LD_probe_address = '0;

    // Power-on reset
    #1;
    check_reset_outputs("por");
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b1;

    // Single store, held until acked
    cycle(1'b1, 32'h0000_1004, 64'h0000_0000_DEAD_BEEF, 2'b10, 1'b0, 32'h0000_1000, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 32'h0000_1004, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 32'h0000_1008, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b1, 32'h0000_1000, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 32'h0000_1000, acc);

    // Spurious acks while empty
    repeat (3) cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);

    // Fill and backpressure: the fifth store is held until an ack frees room
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0000_4000 + 32'(i * 8), 64'(i + 1), 2'b01, 1'b0, 32'h0000_4000, acc);
    cycle(1'b1, 32'h0000_4100, 64'h55, 2'b00, 1'b0, 32'h0000_4018, acc);
    chk("fifth_held", 64'(acc), 64'd0);
    cycle(1'b1, 32'h0000_4100, 64'h55, 2'b00, 1'b1, 32'h0000_4100, acc);
    chk("fifth_held_on_ack", 64'(acc), 64'd0);
    cycle(1'b1, 32'h0000_4100, 64'h55, 2'b00, 1'b0, 32'h0000_4100, acc);
    chk("fifth_accepted", 64'(acc), 64'd1);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, '0, acc);

    // Drain down to two entries, then stream enq+ack so the pointers wrap
    cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
    for (int i = 0; i < 8; i++) begin
      s = 2'($urandom_range(0, 3));
      cycle(1'b1, 32'h0000_8000 + 32'(i * 4), rand_data(s), s, 1'b1, 32'h0000_8000, acc);
    end
    cycle(1'b0, '0, '0, 2'b00, 1'b0, '0, acc);
    chk("wrap_count", 64'(bus.WBUF_count), 64'd2);

    // Drain, then probe block boundaries around one buffered store
    cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
    cycle(1'b1, 32'h2000_0010, 64'h1234, 2'b01, 1'b0, 32'h2000_0010, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 32'h2000_0017, acc);
    chk("probe_hit_17", 64'(bus.LD_probe_conflict), 64'd1);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 32'h2000_0018, acc);
    chk("probe_miss_18", 64'(bus.LD_probe_conflict), 64'd0);
    cycle(1'b0, '0, '0, 2'b00, 1'b1, 32'h2000_0017, acc);
    chk("probe_hit_while_acked", 64'(bus.LD_probe_conflict), 64'd1);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, 32'h2000_0017, acc);
    chk("probe_after_ack", 64'(bus.LD_probe_conflict), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = 2'($urandom_range(0, 3));
      a = 32'h3000_0000 + 32'($urandom_range(0, 31) * 4);
      if (model_q.size() > 0 && $urandom_range(0, 1) == 1)
        p = {model_q[$urandom_range(0, model_q.size() - 1)].addr[31:3], 3'($urandom_range(0, 7))};
      else
        p = 32'h3000_0000 + 32'($urandom_range(0, 127));
      cycle(1'($urandom_range(0, 1)), a, rand_data(s), s,
            1'($urandom_range(0, 2) != 0), p, acc);
    end

    // Reset mid-drain with two entries queued and an ack in flight
    cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
    tries = 0;
    while (model_q.size() > 0 && tries < 10) begin
      cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
      tries++;
    end
    cycle(1'b1, 32'h5000_0000, 64'hA, 2'b00, 1'b0, '0, acc);
    cycle(1'b1, 32'h5000_0040, 64'hB, 2'b00, 1'b0, '0, acc);
    @(negedge CLK);
    bus.WB_wr_valid      = 1'b0;
    bus.DC_wr_ack        = 1'b1;
    bus.LD_probe_address = 32'h5000_0000;
    #1;
    CLR = 1'b0;
    #2;
    check_reset_outputs("mid_reset");
    model_q.delete();
    exp_q.delete();
    @(posedge CLK);
    #1;
    check_reset_outputs("held_reset");
    @(negedge CLK);
    bus.DC_wr_ack = 1'b0;
    #1;
    CLR = 1'b1;
    cycle(1'b0, '0, '0, 2'b00, 1'b1, '0, acc);
    cycle(1'b1, 32'h6000_0008, 64'hC0FFEE, 2'b10, 1'b0, 32'h6000_000F, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b1, 32'h6000_000F, acc);
    cycle(1'b0, '0, '0, 2'b00, 1'b0, '0, acc);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- FIFO write buffer directly downstream of the writeback stage.
- Accepts validated dcache store requests from writeback (data, address, size) and holds them in order. Drains them to the dcache one at a time using a req/ack handshake.
- Drives the `In_write_ready` signal that writeback uses for its stall logic.
- Provides an address-conflict probe so the memory stage can hold loads that overlap a pending store.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- CLR  input  1  asynchronous active-low reset.
- WB_wr_valid  input  1  writeback presents a valid store (validated dcache-write).
- WB_wr_address  input  32  store byte address.
- WB_wr_data  input  64  store data; upper 32 bits are zero unless MM store.
- WB_wr_size  input  2  00 byte, 01 word, 10 dword, 11 qword (MM).
- In_write_ready  output  1  buffer can accept a store this cycle.
- DC_wr_req  output  1  head entry valid and presented to dcache.
- DC_wr_address  output  32  head entry address.
- DC_wr_data  output  64  head entry data.
- DC_wr_size  output  2  head entry size.
- DC_wr_ack  input  1  dcache accepted the head entry this cycle.
- LD_probe_address  input  32  address of a load in the memory stage.
- LD_probe_conflict  output  1  a buffered store overlaps the probed 8-byte block.
- WBUF_count  output  PTR_W+1  number of occupied entries.
- WBUF_empty  output  1  count == 0; used to drain before halt or serialising ops.

Behaviour:
- Storage:
  - DEPTH entries of {address[31:0], data[63:0], size[1:0], valid}.
  - Head pointer rd_ptr, tail pointer wr_ptr (PTR_W bits, wrap modulo DEPTH), counter count (PTR_W+1 bits, 0..DEPTH).
- Reset (CLR low, asynchronous):
  - rd_ptr=0, wr_ptr=0, count=0, all valid bits cleared.
  - Outputs: DC_wr_req=0, LD_probe_conflict=0, WBUF_count=0, WBUF_empty=1, In_write_ready=1.
  - DC_wr_address/data/size read entry 0 and are don't-care while DC_wr_req=0.
  - Reset mid-drain discards all entries; an in-flight ack in that cycle is ignored.
- Ready: In_write_ready = (count != DEPTH), combinational from registered count. No same-cycle dependency on DC_wr_ack; when full, ready stays low even if an ack arrives.
- Enqueue:
  - enq = WB_wr_valid & In_write_ready.
  - On the edge: write the entry at wr_ptr, set its valid bit, wr_ptr+1.
  - WB_wr_valid while not ready is ignored; writeback holds the request (stall).
- Head presentation:
  - DC_wr_req = valid[rd_ptr]; DC_wr_* driven from entry rd_ptr.
  - Latency: a store enqueued at edge N is presented at earliest after edge N; no bypass of an empty buffer.
  - Head fields are stable while DC_wr_req=1 and no ack has been received.
- Dequeue:
  - deq = DC_wr_ack & DC_wr_req.
  - On the edge: clear valid[rd_ptr], rd_ptr+1.
  - Ack with DC_wr_req=0 is ignored.
  - One store retired per ack; back-to-back acks drain one entry per cycle.
- Count: enq&!deq → +1; deq&!enq → −1; both or neither → unchanged.
  - Simultaneous enq+deq is legal whenever 0 < count < DEPTH.
  - At count=0 only enq is possible; at count=DEPTH only deq is possible.
- Ordering: strict FIFO; stores reach dcache in writeback order; no merging or coalescing.
- Conflict probe:
  - LD_probe_conflict = OR over entries of (valid[i] & address[i][31:3] == LD_probe_address[31:3]).
  - Combinational from registered state; does not include the store being enqueued this cycle.
  - An entry being acked this cycle still reports conflict.
- WBUF_empty = (count == 0); WBUF_count = count.
- Invariant: count == number of set valid bits; count never exceeds DEPTH or underflows.

Test Plan:
- Reset/idle:
  - Stimulus: assert CLR=0 mid-cycle with 2 entries queued.
  - Required: immediately DC_wr_req=0, WBUF_empty=1, In_write_ready=1, WBUF_count=0.
- Single store:
  - Stimulus: enqueue addr 0x00001004, data 0x00000000DEADBEEF, size 10 at edge 1.
  - Required: DC_wr_req=1 after edge 1 with those fields held until DC_wr_ack; empty after the ack edge.
- Fill and backpressure:
  - Stimulus: 5 consecutive WB_wr_valid with ack held low.
  - Required: first 4 accepted; In_write_ready=0 once count=4; 5th held. After one ack, ready=1 and the 5th enqueues next edge, count stays 4.
- Simultaneous enq/deq with wrap:
  - Stimulus: with count=2, drive enq+ack every cycle for 8 cycles.
  - Required: count remains 2; pointers wrap; dcache sees stores in exact enqueue order.
- Conflict probe:
  - Stimulus: buffer a store to 0x2000_0010; probe 0x2000_0017.
  - Required: conflict=1 for probe 0x2000_0017; conflict=0 for probe 0x2000_0018; conflict=0 after that entry is acked.
- Spurious ack:
  - Stimulus: DC_wr_ack=1 while empty.
  - Required: no pointer or count change; WBUF_count stays 0.
